// File: rtl/mac_accumulator.sv
// mac_accumulator
// Accumulates a frame of signed products coming from an upstream 16x16
// multiplier and presents the frame sum, beat count and a sticky overflow
// flag once the last beat of the frame has been taken.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   clr        synchronous frame abort (clears sum, count, flag, held result)
//   in_valid   in_prod/in_last hold a beat
//   in_ready   block accepts a beat this cycle (ACCUM state)
//   in_prod    signed product, PROD_W bits
//   in_last    final beat of the frame
//   out_valid  frame result presented (HOLD state)
//   out_ready  downstream accepts the result
//   out_acc    signed frame sum, ACC_W bits
//   out_cnt    beats in the frame, modulo 2^CNT_W
//   out_ovf    sticky: some addition in the frame overflowed ACC_W
//
// Build option
//   MAC_ACCUMULATOR_SATURATE_EN  when defined, an overflowing addition clamps
//                                the sum to the most positive/negative value;
//                                otherwise the sum wraps two's-complement.
module mac_accumulator #(
   parameter int PROD_W = 32,
   parameter int ACC_W  = 40,
   parameter int CNT_W  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [PROD_W-1:0] in_prod,
   input  logic                     in_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [ACC_W-1:0]  out_acc,
   output logic [CNT_W-1:0]         out_cnt,
   output logic                     out_ovf
);

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t                   r_state;
   logic                     r_in_ready;
   logic                     r_out_valid;
   logic signed [ACC_W-1:0]  r_acc;
   logic [CNT_W-1:0]         r_cnt;
   logic                     r_ovf;

   logic signed [ACC_W-1:0]  w_prod_ext;
   logic signed [ACC_W-1:0]  w_sum;
   logic signed [ACC_W-1:0]  w_acc_nxt;
   logic                     w_add_ovf;
   logic                     w_accept;

   // Signed overflow: both operands share a sign and the result does not.
   function automatic logic add_ovf(input logic signed [ACC_W-1:0] a,
                                    input logic signed [ACC_W-1:0] b,
                                    input logic signed [ACC_W-1:0] s);
      return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
   endfunction

`ifdef MAC_ACCUMULATOR_SATURATE_EN
   // On overflow both operands have the sign of the addend, so the addend's
   // sign picks the rail to clamp to.
   function automatic logic signed [ACC_W-1:0] sat_clamp(
         input logic signed [ACC_W-1:0] s,
         input logic                    neg,
         input logic                    ovf);
      if (!ovf)
         return s;
      else if (neg)
         return {1'b1, {(ACC_W-1){1'b0}}};
      else
         return {1'b0, {(ACC_W-1){1'b1}}};
   endfunction
`endif

   assign w_prod_ext = {{(ACC_W-PROD_W){in_prod[PROD_W-1]}}, in_prod};
   assign w_sum      = r_acc + w_prod_ext;
   assign w_add_ovf  = add_ovf(r_acc, w_prod_ext, w_sum);
   assign w_accept   = in_valid & r_in_ready;

`ifdef MAC_ACCUMULATOR_SATURATE_EN
   assign w_acc_nxt = sat_clamp(w_sum, w_prod_ext[ACC_W-1], w_add_ovf);
`else
   assign w_acc_nxt = w_sum;
`endif

   // Control and accumulator state; in_ready/out_valid are registered
   // copies of the state decode so they change only at an edge or on rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ACCUM;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_ovf       <= 1'b0;
      end else if (clr) begin
         r_state     <= ACCUM;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_ovf       <= 1'b0;
      end else begin
         case (r_state)
            ACCUM: begin
               if (w_accept) begin
                  r_acc <= w_acc_nxt;
                  r_cnt <= r_cnt + CNT_W'(1);
                  r_ovf <= r_ovf | w_add_ovf;
                  if (in_last) begin
                     r_state     <= HOLD;
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  r_state     <= ACCUM;
                  r_in_ready  <= 1'b1;
                  r_out_valid <= 1'b0;
                  r_acc       <= '0;
                  r_cnt       <= '0;
                  r_ovf       <= 1'b0;
               end
            end
            default: begin
               r_state <= ACCUM;
            end
         endcase
      end
   end

   // The accumulator itself is the result: it is frozen while in HOLD.
   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_acc   = r_acc;
   assign out_cnt   = r_cnt;
   assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_mac_accumulator.sv
module tb_mac_accumulator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid  [3];
   logic        in_last   [3];
   logic        clr       [3];
   logic        out_ready [3];
   logic [31:0] in_prod   [3];
   logic        in_ready  [3];
   logic        out_valid [3];
   logic        out_ovf   [3];

   logic [39:0] acc0, acc2;
   logic [32:0] acc1;
   logic [7:0]  cnt0, cnt1;
   logic [1:0]  cnt2;
   logic [39:0] oacc [3];
   logic [7:0]  ocnt [3];

   always_comb begin
      oacc[0] = acc0;
      oacc[1] = {7'd0, acc1};
      oacc[2] = acc2;
      ocnt[0] = cnt0;
      ocnt[1] = cnt1;
      ocnt[2] = {6'd0, cnt2};
   end

   // Default build
   mac_accumulator u0 (
      .clk(clk), .rst(rst), .clr(clr[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_prod(in_prod[0]), .in_last(in_last[0]), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .out_acc(acc0), .out_cnt(cnt0), .out_ovf(out_ovf[0]));

   // Narrow accumulator for overflow cases
   mac_accumulator #(.ACC_W(33)) u1 (
      .clk(clk), .rst(rst), .clr(clr[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_prod(in_prod[1]), .in_last(in_last[1]), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .out_acc(acc1), .out_cnt(cnt1), .out_ovf(out_ovf[1]));

   // Narrow counter for wrap case
   mac_accumulator #(.CNT_W(2)) u2 (
      .clk(clk), .rst(rst), .clr(clr[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .in_prod(in_prod[2]), .in_last(in_last[2]), .out_valid(out_valid[2]),
      .out_ready(out_ready[2]), .out_acc(acc2), .out_cnt(cnt2), .out_ovf(out_ovf[2]));

   typedef struct {
      int          inst;
      logic [39:0] acc;
      logic [7:0]  cnt;
      logic        ovf;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   // Monitor: pops the scoreboard on every output handshake
   exp_t e;
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (out_valid[k] && out_ready[k]) begin
            if (sb.size() == 0) begin
               n_chk++;
               $display("FAIL spurious_out: inst %0d presented acc=%0h, expected no result", k, oacc[k]);
            end else begin
               e = sb.pop_front();
               chk("out_inst", 64'(k), 64'(e.inst));
               chk("out_acc", 64'(oacc[k]), 64'(e.acc));
               chk("out_cnt", 64'(ocnt[k]), 64'(e.cnt));
               chk("out_ovf", 64'(out_ovf[k]), 64'(e.ovf));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input int k, input logic [31:0] p, input logic l);
      in_valid[k] = 1'b1;
      in_prod[k]  = p;
      in_last[k]  = l;
      tick();
      in_valid[k] = 1'b0;
      in_last[k]  = 1'b0;
   endtask

   task automatic push(input int k, input logic [39:0] a, input logic [7:0] c, input logic o);
      exp_t x;
      x.inst = k;
      x.acc  = a;
      x.cnt  = c;
      x.ovf  = o;
      sb.push_back(x);
   endtask

   task automatic drain(input int k, input string nm);
      for (int i = 0; i < 20 && out_valid[k]; i++) tick();
      chk(nm, 64'(out_valid[k]), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_valid[k]  = 1'b0;
         in_last[k]   = 1'b0;
         clr[k]       = 1'b0;
         out_ready[k] = 1'b1;
         in_prod[k]   = 32'd0;
      end
      tick();
      tick();
      chk("rst_in_ready", 64'(in_ready[0]), 64'd1);
      chk("rst_out_valid", 64'(out_valid[0]), 64'd0);
      chk("rst_acc", 64'(oacc[0]), 64'd0);
      chk("rst_cnt", 64'(ocnt[0]), 64'd0);
      chk("rst_ovf", 64'(out_ovf[0]), 64'd0);
      rst = 1'b0;
      tick();

      // 6 + (-3) + 100
      push(0, 40'd103, 8'd3, 1'b0);
      beat(0, 32'd6, 1'b0);
      beat(0, 32'hFFFF_FFFD, 1'b0);
      beat(0, 32'd100, 1'b1);
      chk("t1_latency", 64'(out_valid[0]), 64'd1);
      drain(0, "t1_drain");

      // Single negative beat, sign-extended
      push(0, 40'hFF_C000_0000, 8'd1, 1'b0);
      beat(0, 32'hC000_0000, 1'b1);
      drain(0, "t2_drain");

      // Held result with back-pressure and in_valid still asserted
      out_ready[0] = 1'b0;
      push(0, 40'd50, 8'd1, 1'b0);
      beat(0, 32'd50, 1'b1);
      in_valid[0] = 1'b1;
      in_prod[0]  = 32'd7;
      in_last[0]  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_in_ready", 64'(in_ready[0]), 64'd0);
         chk("hold_acc", 64'(oacc[0]), 64'd50);
         chk("hold_valid", 64'(out_valid[0]), 64'd1);
      end
      in_valid[0]  = 1'b0;
      in_last[0]   = 1'b0;
      out_ready[0] = 1'b1;
      tick();
      chk("release_in_ready", 64'(in_ready[0]), 64'd1);
      chk("release_acc", 64'(oacc[0]), 64'd0);
      chk("release_cnt", 64'(ocnt[0]), 64'd0);

      // ACC_W=33: positive overflow, then a clean frame, then negative overflow
`ifdef MAC_ACCUMULATOR_SATURATE_EN
      push(1, 40'h0_FFFF_FFFF, 8'd3, 1'b1);
`else
      push(1, 40'h1_7FFF_FFFD, 8'd3, 1'b1);
`endif
      beat(1, 32'h7FFF_FFFF, 1'b0);
      beat(1, 32'h7FFF_FFFF, 1'b0);
      beat(1, 32'h7FFF_FFFF, 1'b1);
      drain(1, "ovfp_drain");
      push(1, 40'd3, 8'd2, 1'b0);
      beat(1, 32'd1, 1'b0);
      beat(1, 32'd2, 1'b1);
      drain(1, "clean_drain");
`ifdef MAC_ACCUMULATOR_SATURATE_EN
      push(1, 40'h1_0000_0000, 8'd3, 1'b1);
`else
      push(1, 40'h0_8000_0000, 8'd3, 1'b1);
`endif
      beat(1, 32'h8000_0000, 1'b0);
      beat(1, 32'h8000_0000, 1'b0);
      beat(1, 32'h8000_0000, 1'b1);
      drain(1, "ovfn_drain");

      // clr mid-frame, colliding with an offered beat
      beat(0, 32'd1, 1'b0);
      beat(0, 32'd2, 1'b0);
      clr[0]      = 1'b1;
      in_valid[0] = 1'b1;
      in_prod[0]  = 32'd100;
      in_last[0]  = 1'b1;
      tick();
      clr[0]      = 1'b0;
      in_valid[0] = 1'b0;
      in_last[0]  = 1'b0;
      chk("clr_valid", 64'(out_valid[0]), 64'd0);
      chk("clr_cnt", 64'(ocnt[0]), 64'd0);
      push(0, 40'd12, 8'd2, 1'b0);
      beat(0, 32'd5, 1'b0);
      beat(0, 32'd7, 1'b1);
      drain(0, "clr_drain");

      // clr drops a held result
      out_ready[0] = 1'b0;
      beat(0, 32'd9, 1'b1);
      chk("clrh_pre_valid", 64'(out_valid[0]), 64'd1);
      clr[0] = 1'b1;
      tick();
      clr[0] = 1'b0;
      chk("clrh_valid", 64'(out_valid[0]), 64'd0);
      chk("clrh_in_ready", 64'(in_ready[0]), 64'd1);
      chk("clrh_acc", 64'(oacc[0]), 64'd0);
      out_ready[0] = 1'b1;

      // Asynchronous reset while holding a result
      out_ready[0] = 1'b0;
      beat(0, 32'd4, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 64'(out_valid[0]), 64'd0);
      chk("arst_in_ready", 64'(in_ready[0]), 64'd1);
      chk("arst_acc", 64'(oacc[0]), 64'd0);
      tick();
      rst = 1'b0;
      out_ready[0] = 1'b1;
      push(0, 40'd3, 8'd1, 1'b0);
      beat(0, 32'd3, 1'b1);
      drain(0, "arst_drain");

      // CNT_W=2: five beats wrap the count to 1
      push(2, 40'd5, 8'd1, 1'b0);
      for (int i = 0; i < 4; i++) beat(2, 32'd1, 1'b0);
      beat(2, 32'd1, 1'b1);
      drain(2, "wrap_drain");

      for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
